// File: rtl/lcd_frame_reader.sv
//------------------------------------------------------------------------------
// Module      : lcd_frame_reader
// Description : LCD raster timing + SDRAM read-FIFO pixel unpacker (optional
//               colour-bar generator when TEST_PATTERN_EN is defined).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_frame_reader #(
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int H_SYNC   = 1,
    parameter int H_BACK   = 215,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 1,
    parameter int V_BACK   = 34
) (
    input  logic        LCD_PIXCLK,
    input  logic        iRst,
    input  logic        iRd_empty,
    input  logic [15:0] rd1_data,
    input  logic [15:0] rd2_data,
    input  logic        iPattern,
    output logic        oRead,
    output logic        oFrameStart,
    output logic [7:0]  oRed,
    output logic [7:0]  oGreen,
    output logic [7:0]  oBlue,
    output logic        oHSD,
    output logic        oVSD,
    output logic        oDEN,
    output logic        oUnderflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] C_H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] C_HS_BEG   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]  C_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  C_VS_BEG   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  C_VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    // Stage 0: raster counters
    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [10:0] w_h_nxt;
    logic [9:0]  w_v_nxt;

    always_comb begin
        w_h_nxt = r_h_cnt + 11'd1;
        w_v_nxt = r_v_cnt;
        if (r_h_cnt == C_H_LAST) begin
            w_h_nxt = '0;
            if (r_v_cnt == C_V_LAST) begin
                w_v_nxt = '0;
            end else begin
                w_v_nxt = r_v_cnt + 10'd1;
            end
        end
    end

    logic w_act0;
    logic w_hs0;
    logic w_vs0;
    logic w_act_nxt;

    assign w_act0    = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    assign w_hs0     = (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
    assign w_vs0     = (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);
    assign w_act_nxt = (w_h_nxt < C_H_ACT) && (w_v_nxt < C_V_ACT);

    logic w_pat_sel;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] w_bar0;
    logic       r_pat0;
    logic       r_pat1;
    logic [2:0] r_bar1;

    assign w_pat_sel = iPattern;

    always_comb begin
        w_bar0 = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_h_cnt >= 11'(k * BAR_W)) begin
                w_bar0 = 3'(k);
            end
        end
    end

    always_ff @(posedge LCD_PIXCLK) begin
        if (iRst) begin
            r_pat0 <= 1'b0;
            r_pat1 <= 1'b0;
            r_bar1 <= 3'd0;
        end else begin
            r_pat0 <= w_pat_sel;
            r_pat1 <= r_pat0;
            r_bar1 <= w_bar0;
        end
    end
`else
    logic unused_pattern;

    assign w_pat_sel      = 1'b0;
    assign unused_pattern = iPattern;
`endif

    // The read decision is made for the slot the counters are about to enter,
    // so the oRead flop is high in the same cycle as that slot.
    logic w_read_nxt;
    logic w_skip_nxt;

    assign w_read_nxt = w_act_nxt && !iRd_empty && !w_pat_sel;
    assign w_skip_nxt = w_act_nxt &&  iRd_empty && !w_pat_sel;

    logic r_read;
    logic r_underflow;

    always_ff @(posedge LCD_PIXCLK) begin
        if (iRst) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= C_V_ACT;
            r_read      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            r_read  <= w_read_nxt;
            if (w_skip_nxt) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Stage 1: FIFO data is on rd*_data while these flags describe its slot
    logic r_act1;
    logic r_hs1;
    logic r_vs1;
    logic r_read1;

    always_ff @(posedge LCD_PIXCLK) begin
        if (iRst) begin
            r_act1  <= 1'b0;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_read1 <= 1'b0;
        end else begin
            r_act1  <= w_act0;
            r_hs1   <= w_hs0;
            r_vs1   <= w_vs0;
            r_read1 <= r_read;
        end
    end

    logic [7:0] w_red;
    logic [7:0] w_green;
    logic [7:0] w_blue;

    always_comb begin
        w_red   = 8'd0;
        w_green = 8'd0;
        w_blue  = 8'd0;
        if (r_read1) begin
            w_red   = rd2_data[9:2];
            w_green = {rd1_data[14:10], rd2_data[14:12]};
            w_blue  = rd1_data[9:2];
        end
`ifdef TEST_PATTERN_EN
        // Bar index bits map to inverted channel enables: G=bit2, R=bit1, B=bit0
        if (r_pat1 && r_act1) begin
            w_red   = {8{~r_bar1[1]}};
            w_green = {8{~r_bar1[2]}};
            w_blue  = {8{~r_bar1[0]}};
        end
`endif
    end

    logic unused_bits;
    assign unused_bits = ^{rd1_data[15], rd1_data[1:0],
                           rd2_data[15], rd2_data[11:10], rd2_data[1:0]};

    // Pin registers
    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;
    logic       r_hsd;
    logic       r_vsd;
    logic       r_den;

    always_ff @(posedge LCD_PIXCLK) begin
        if (iRst) begin
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
            r_hsd   <= 1'b1;
            r_vsd   <= 1'b1;
            r_den   <= 1'b0;
        end else begin
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
            r_hsd   <= ~r_hs1;
            r_vsd   <= ~r_vs1;
            r_den   <= r_act1;
        end
    end

    assign oRead       = r_read;
    assign oUnderflow  = r_underflow;
    assign oRed        = r_red;
    assign oGreen      = r_green;
    assign oBlue       = r_blue;
    assign oHSD        = r_hsd;
    assign oVSD        = r_vsd;
    assign oDEN        = r_den;
    assign oFrameStart = (r_h_cnt == 11'd0) && (r_v_cnt == C_V_ACT) && !iRst;

endmodule

`default_nettype wire

// File: tb/tb_lcd_frame_reader.sv
//------------------------------------------------------------------------------
// Module      : tb_lcd_frame_reader
// Description : Self-checking bench for lcd_frame_reader (small raster model
//               plus a full-size instance for the startup latency).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lcd_frame_reader;

    localparam int HA = 16, HF = 3, HS = 2, HB = 5, HT = HA + HF + HS + HB;
    localparam int VA = 5,  VF = 2, VS = 1, VB = 2, VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        iRst, iRd_empty, iPattern;
    logic [15:0] rd1_data, rd2_data;
    logic        oRead, oFrameStart, oHSD, oVSD, oDEN, oUnderflow;
    logic [7:0]  oRed, oGreen, oBlue;

    lcd_frame_reader #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .LCD_PIXCLK(clk), .iRst(iRst), .iRd_empty(iRd_empty),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .iPattern(iPattern),
        .oRead(oRead), .oFrameStart(oFrameStart),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oHSD(oHSD), .oVSD(oVSD), .oDEN(oDEN), .oUnderflow(oUnderflow)
    );

    // Full-size instance for the startup latency
    logic        b_rst;
    logic        b_read, b_fs, b_hsd, b_vsd, b_den, b_unf;
    logic [7:0]  b_r, b_g, b_b;
    logic [15:0] b_zero = 16'h0000;
    bit          big_done = 1'b0;

    lcd_frame_reader big (
        .LCD_PIXCLK(clk), .iRst(b_rst), .iRd_empty(1'b0),
        .rd1_data(b_zero), .rd2_data(b_zero), .iPattern(1'b0),
        .oRead(b_read), .oFrameStart(b_fs),
        .oRed(b_r), .oGreen(b_g), .oBlue(b_b),
        .oHSD(b_hsd), .oVSD(b_vsd), .oDEN(b_den), .oUnderflow(b_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit act; bit hs; bit vs; bit rd; bit pat; int h; int v;
    } slot_t;

    // Linear position 0 is (h=0, v=VA), where the raster sits after reset.
    function automatic slot_t slot_at(input int pos);
        slot_t s;
        int lin;
        lin   = (pos + VA * HT) % FR;
        s.h   = lin % HT;
        s.v   = lin / HT;
        s.act = (s.h < HA) && (s.v < VA);
        s.hs  = (s.h >= HA + HF) && (s.h < HA + HF + HS);
        s.vs  = (s.v >= VA + VF) && (s.v < VA + VF + VS);
        s.rd  = 1'b0;
        s.pat = 1'b0;
        return s;
    endfunction

    function automatic logic [23:0] bar_rgb(input int h);
        case (h / (HA / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    int          m_pos;
    slot_t       m_s0, m_s1;
    logic [23:0] m_rgb;
    bit          m_den, m_hsd, m_vsd, m_unf;

    task automatic model_reset();
        slot_t z;
        z      = '{default: 0};
        m_pos  = 0;
        m_s0   = slot_at(0);
        m_s1   = z;
        m_rgb  = 24'h0;
        m_den  = 1'b0;
        m_hsd  = 1'b1;
        m_vsd  = 1'b1;
        m_unf  = 1'b0;
    endtask

    task automatic model_edge(input bit rst, input bit empty, input bit pat,
                              input logic [15:0] d1, input logic [15:0] d2);
        bit pe;
`ifdef TEST_PATTERN_EN
        pe = pat;
`else
        pe = 1'b0;
`endif
        if (rst) begin
            model_reset();
        end else begin
            m_den = m_s1.act;
            m_hsd = !m_s1.hs;
            m_vsd = !m_s1.vs;
            if (m_s1.pat && m_s1.act) m_rgb = bar_rgb(m_s1.h);
            else if (m_s1.rd)         m_rgb = {d2[9:2], d1[14:10], d2[14:12], d1[9:2]};
            else                      m_rgb = 24'h0;
            m_s1     = m_s0;
            m_pos    = (m_pos + 1) % FR;
            m_s0     = slot_at(m_pos);
            m_s0.pat = pe;
            m_s0.rd  = m_s0.act && !empty && !pe;
            if (m_s0.act && empty && !pe) m_unf = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [31:0] act, exp;
        bit fs;
        fs  = (m_pos == 0) && !iRst;
        exp = {2'b00, m_s0.rd, fs, m_rgb, m_hsd, m_vsd, m_den, m_unf};
        act = {2'b00, oRead, oFrameStart, oRed, oGreen, oBlue, oHSD, oVSD, oDEN, oUnderflow};
        chk($sformatf("outputs@pos%0d", m_pos), act, exp);
    endtask

    // One clock cycle: drive inputs, compare, clock, advance the model.
    task automatic step(input bit rst, input bit empty, input bit pat,
                        input logic [15:0] d1, input logic [15:0] d2);
        iRst = rst; iRd_empty = empty; iPattern = pat; rd1_data = d1; rd2_data = d2;
        #1;
        check_all();
        @(posedge clk);
        model_edge(rst, empty, pat, d1, d2);
        #1;
    endtask

    typedef struct {
        logic [15:0] d1; logic [15:0] d2; logic [7:0] r; logic [7:0] g; logic [7:0] b;
    } vec_t;

    // ---------------- full-size startup ----------------
    initial begin
        int cyc;
        int line_reads;
        b_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 b_rst = 1'b0;
        #1;
        chk("big_release_fs", {31'd0, b_fs}, 32'd1);
        chk("big_release_pins", {7'd0, b_read, b_r, b_g, b_b, b_hsd, b_vsd, b_den, b_unf},
            {7'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0});
        cyc = 0;
        while (!b_read && cyc < 60000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("big_first_read_cycle", cyc, 47520);
        line_reads = 0;
        for (int i = 0; i < 1056; i++) begin
            if (b_read) line_reads++;
            @(posedge clk); #1;
        end
        chk("big_reads_first_line", line_reads, 800);
        big_done = 1'b1;
    end

    // ---------------- small raster tests ----------------
    initial begin
        vec_t vecs[4];
        int   total, line_cnt[VT], n, tgt;
        vecs[0] = '{16'h7FFC, 16'h53F8, 8'hFE, 8'hFD, 8'hFF};
        vecs[1] = '{16'h0400, 16'h1004, 8'h01, 8'h09, 8'h00};
        vecs[2] = '{16'h0204, 16'h4200, 8'h80, 8'h04, 8'h81};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF};

        iRst = 1'b1; iRd_empty = 1'b0; iPattern = 1'b0; rd1_data = '0; rd2_data = '0;
        @(posedge clk); #1;
        model_reset();
        repeat (4) step(1, 0, 0, 16'(($urandom)), 16'(($urandom)));
        iRst = 1'b0; #1;
        chk("release_fs", {31'd0, oFrameStart}, 32'd1);
        chk("release_pins", {7'd0, oRead, oRed, oGreen, oBlue, oHSD, oVSD, oDEN, oUnderflow},
            {7'd0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0});

        // Phase A: FIFO never empty, exactly one frame from frame start
        total = 0;
        for (int i = 0; i < VT; i++) line_cnt[i] = 0;
        for (int i = 0; i < FR; i++) begin
            if (oRead) begin
                total++;
                line_cnt[slot_at(m_pos).v]++;
            end
            step(0, 0, 0, 16'($urandom), 16'($urandom));
        end
        chk("frame_reads", total, HA * VA);
        for (int i = 0; i < VA; i++) chk($sformatf("line%0d_reads", i), line_cnt[i], HA);
        chk("blank_line_reads", line_cnt[VA], 0);

        // Phase B: random empties, pattern select and rare resets
        for (int i = 0; i < 2 * FR; i++)
            step(($urandom_range(199) == 0), ($urandom_range(3) == 0), 1'($urandom),
                 16'($urandom), 16'($urandom));

        // Phase C: three skipped pixels at line 1, h=5..7
        step(1, 0, 0, 16'h0, 16'h0);
        tgt = (1 * HT + 5 - VA * HT + FR) % FR;
        n = 0;
        for (int i = 0; i < FR && m_pos <= tgt + 24; i++) begin
            if (oRead && slot_at(m_pos).v == 1) n++;
            step(0, (m_pos >= tgt - 1 && m_pos <= tgt + 1), 0, 16'($urandom), 16'($urandom));
            if (m_pos >= tgt + 2 && m_pos <= tgt + 4)
                chk("skipped_pixel", {7'd0, oDEN, oRed, oGreen, oBlue}, {7'd0, 1'b1, 24'h0});
        end
        chk("underflow_line_reads", n, HA - 3);
        chk("underflow_set", {31'd0, oUnderflow}, 32'd1);

        // Phase D: reset mid-frame at (h=8, v=2)
        tgt = (2 * HT + 8 - VA * HT + FR) % FR;
        for (int i = 0; i < FR && m_pos != tgt; i++) step(0, 0, 0, 16'($urandom), 16'($urandom));
        chk("underflow_sticky", {31'd0, oUnderflow}, 32'd1);
        step(1, 0, 0, 16'h0, 16'h0);
        iRst = 1'b0; #1;
        chk("midreset_state", {29'd0, oFrameStart, oRead, oUnderflow}, {29'd0, 3'b100});

        // Phase E: table-driven unpack
        foreach (vecs[k]) begin
            n = 0;
            while (!m_s0.rd && n < 2 * FR) begin
                step(0, 0, 0, 16'($urandom), 16'($urandom));
                n++;
            end
            chk($sformatf("vec%0d_read_found", k), {31'd0, oRead}, 32'd1);
            step(0, 0, 0, 16'($urandom), 16'($urandom));
            step(0, 0, 0, vecs[k].d1, vecs[k].d2);
            chk($sformatf("vec%0d_rgb", k), {7'd0, oDEN, oRed, oGreen, oBlue},
                {7'd0, 1'b1, vecs[k].r, vecs[k].g, vecs[k].b});
        end

`ifdef TEST_PATTERN_EN
        // Phase F: colour bars, no reads
        n = 0;
        for (int i = 0; i < FR; i++) begin
            slot_t d;
            if (oRead) n++;
            step(0, 0, 1, 16'($urandom), 16'($urandom));
            d = slot_at((m_pos - 2 + FR) % FR);
            if (i > 3 && d.v == 0 && d.h == 0)
                chk("bar_x0", {8'd0, oRed, oGreen, oBlue}, 32'h00FFFFFF);
            if (i > 3 && d.v == 0 && d.h == 3)
                chk("bar_x3", {8'd0, oRed, oGreen, oBlue}, 32'h00FFFF00);
            if (i > 3 && d.v == 0 && d.h == HA - 1)
                chk("bar_xlast", {8'd0, oRed, oGreen, oBlue}, 32'h00000000);
        end
        chk("pattern_reads", n, 0);
`endif

        n = 0;
        while (!big_done && n < 70000) begin
            @(posedge clk);
            n++;
        end
        chk("big_done", {31'd0, big_done}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
